// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and width limit.
package shift_seq_pkg;

  localparam int unsigned N_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_datapath.sv
// Shift register and receive-word capture for the shift sequencer.
// Direction is chosen at build time: SHIFT_SEQ_CTRL_MSB_FIRST_EN selects
// MSB-first, otherwise LSB-first.
module shift_seq_datapath
  import shift_seq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         shift,
  input  logic         capture,
  input  logic [N-1:0] tx_data,
  input  logic         sin,
  output logic         sout,
  output logic [N-1:0] rx_data
);

  logic [N-1:0] shreg;
  logic [N-1:0] shreg_nxt;

  // Next shifted value; also the completed receive word on the last shift
`ifdef SHIFT_SEQ_CTRL_MSB_FIRST_EN
  assign shreg_nxt = {shreg[N-2:0], sin};
  assign sout      = shreg[N-1];
`else
  assign shreg_nxt = {sin, shreg[N-1:1]};
  assign sout      = shreg[0];
`endif

  // Load on accept, shift while enabled, capture the received word at the end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg   <= '0;
      rx_data <= '0;
    end else begin
      if (load) begin
        shreg <= tx_data;
      end else if (shift) begin
        shreg <= shreg_nxt;
      end
      if (capture) begin
        rx_data <= shreg_nxt;
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an N-bit full-duplex serialiser: start/ready handshake,
// N shift cycles, one-cycle done pulse. Optional build macro
// SHIFT_SEQ_CTRL_MSB_FIRST_EN reverses the shift direction in the datapath.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  tx_data,
  input  logic          sin,
  output logic          ready,
  output logic          busy,
  output logic          sout,
  output logic          done,
  output logic [N-1:0]  rx_data,
  output logic [CW-1:0] bit_cnt
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          load;
  logic          shift;
  logic          capture;
  logic          last_bit;

  assign last_bit = (bit_cnt == CW'(N - 1));

  // Next-state, counter and datapath strobes; abort freezes the shift register
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          shift = 1'b1;
          if (last_bit) begin
            capture   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = bit_cnt + CW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and registered status flags decoded from the next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      ready   <= (state_nxt == IDLE);
      busy    <= (state_nxt == SHIFT);
      done    <= (state_nxt == DONE);
    end
  end

  shift_seq_datapath #(
    .N (N)
  ) u_datapath (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load),
    .shift   (shift),
    .capture (capture),
    .tx_data (tx_data),
    .sin     (sin),
    .sout    (sout),
    .rx_data (rx_data)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: the driver pushes expected serial
// bits, counter values and received words; a negedge monitor pops and compares.
module tb_shift_seq_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N);
`ifdef SHIFT_SEQ_CTRL_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  tx_data = '0;
  logic          sin = 1'b0;
  logic          ready, busy, sout, done;
  logic [N-1:0]  rx_data;
  logic [CW-1:0] bit_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_accept = -100;
  logic [N-1:0] model_rx = '0;

  logic         exp_sout[$];
  int           exp_cnt[$];
  logic [N-1:0] exp_rx[$];
  int           exp_dcyc[$];

  shift_seq_ctrl #(.N(N)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .abort   (abort),
    .tx_data (tx_data),
    .sin     (sin),
    .ready   (ready),
    .busy    (busy),
    .sout    (sout),
    .done    (done),
    .rx_data (rx_data),
    .bit_cnt (bit_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One transfer; abort_at / rst_at >= 0 interrupt it during that shift cycle
  task automatic run_xfer(input logic [N-1:0] tx, input logic [N-1:0] s,
                          input int abort_at, input int rst_at, input bit b2b);
    int t0;
    int nb;
    bit r;
    bit got;
    logic [N-1:0] rxw;
    start   = 1'b1;
    tx_data = tx;
    abort   = 1'($urandom);
    got     = 1'b0;
    for (int i = 0; i < 4 * N + 8 && !got; i++) begin
      r = ready;
      @(posedge CLK);
      #1;
      if (r) got = 1'b1;
      else abort = 1'($urandom);
    end
    abort = 1'b0;
    if (!got) begin
      fail_now("accept_timeout");
      start = 1'b0;
      return;
    end
    t0 = cyc;
    if (b2b) chk("b2b_accept_cycle", 32'(t0), 32'(last_accept + N + 2));
    last_accept = t0;
    nb = (abort_at >= 0) ? abort_at + 1 : (rst_at >= 0) ? rst_at : N;
    for (int k = 0; k < nb; k++) begin
      exp_sout.push_back(MSB ? tx[N-1-k] : tx[k]);
      exp_cnt.push_back(k);
    end
    for (int k = 0; k < N; k++) begin
      if (MSB) rxw[N-1-k] = s[k];
      else     rxw[k]     = s[k];
    end
    if (abort_at < 0 && rst_at < 0) begin
      exp_rx.push_back(rxw);
      exp_dcyc.push_back(t0 + N);
    end
    for (int k = 0; k < N; k++) begin
      if (k == rst_at) begin
        RST = 1'b1;
        model_rx = '0;
        #2;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'd0);
        chk("rst_cnt", 32'(bit_cnt), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        break;
      end
      sin     = s[k];
      abort   = (k == abort_at);
      start   = 1'($urandom);
      tx_data = N'($urandom);
      @(posedge CLK);
      #1;
      if (k == abort_at) begin
        abort = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        break;
      end
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  // Monitor: compares every cycle against the scoreboard queues and held rx word
  initial begin
    logic [N-1:0] erx;
    int ec;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("ready_vs_state", 32'(ready), 32'(!(busy || done)));
        if (busy) begin
          if (exp_sout.size() == 0) fail_now("busy_without_transfer");
          else begin
            chk("sout", 32'(sout), 32'(exp_sout.pop_front()));
            chk("bit_cnt", 32'(bit_cnt), 32'(exp_cnt.pop_front()));
          end
        end else begin
          chk("bit_cnt_idle", 32'(bit_cnt), 32'd0);
        end
        if (done) begin
          if (exp_rx.size() == 0) fail_now("done_without_transfer");
          else begin
            erx = exp_rx.pop_front();
            ec  = exp_dcyc.pop_front();
            chk("done_cycle", 32'(cyc), 32'(ec));
            model_rx = erx;
          end
        end
        chk("rx_data", 32'(rx_data), 32'(model_rx));
      end
    end
  end

  initial begin
    int ab;
    int rs;
    bit b2b;
    bit prev_ok;
    RST = 1'b1;
    idle_cycles(2);
    @(negedge CLK);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sout", 32'(sout), 32'd0);
    chk("reset_rx", 32'(rx_data), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    run_xfer(4'b1010, 4'b1011, -1, -1, 1'b0);
    idle_cycles(1);
    chk("ready_after_done", 32'(ready), 32'd1);
    idle_cycles(2);

    run_xfer(4'b0011, N'($urandom), -1, -1, 1'b0);
    run_xfer(4'b1100, N'($urandom), -1, -1, 1'b1);
    idle_cycles(2);

    run_xfer(N'($urandom), N'($urandom), 2, -1, 1'b0);
    idle_cycles(1);
    run_xfer(N'($urandom), N'($urandom), 3, -1, 1'b0);
    idle_cycles(1);
    run_xfer(N'($urandom), N'($urandom), -1, 1, 1'b0);
    run_xfer(N'($urandom), N'($urandom), -1, -1, 1'b0);

    prev_ok = 1'b1;
    for (int t = 0; t < 30; t++) begin
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      b2b = prev_ok && ($urandom_range(0, 1) == 1);
      if (!b2b) idle_cycles($urandom_range(0, 3));
      run_xfer(N'($urandom), N'($urandom), ab, -1, b2b);
      prev_ok = (ab < 0);
    end

    idle_cycles(N + 4);
    chk("sout_queue_drained", 32'(exp_sout.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_rx.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
